// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared widths, depth helper and FIFO operation encoding for
//               the UART receive path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int UART_DBIT   = 8;
    localparam int FIFO_ADDR_W = 4;
    localparam int FIFO_DEPTH  = 2 ** FIFO_ADDR_W;

    // Encoding is {write accepted, read accepted}.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_RD    = 2'b01,
        OP_WR    = 2'b10,
        OP_WR_RD = 2'b11
    } fifo_op_e;

    function automatic int fifo_depth(input int addr_w);
        return 2 ** addr_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_fifo_ctrl.sv
// ============================================================================
// Module      : uart_fifo_ctrl
// Description : Pointer and flag control for the UART receive FIFO. The ovf
//               port exists only when UART_RX_FIFO_OVF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic              rd,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W-1:0] rd_ptr,
    output logic              empty,
    output logic              full,
    output logic              loaded
`ifdef UART_RX_FIFO_OVF_EN
   ,output logic              ovf
`endif
);

    logic              rd_en;
    logic [ADDR_W-1:0] wr_ptr_inc;
    logic [ADDR_W-1:0] rd_ptr_inc;
    logic [ADDR_W-1:0] wr_ptr_nxt;
    logic [ADDR_W-1:0] rd_ptr_nxt;
    logic              empty_nxt;
    logic              full_nxt;
    fifo_op_e          op;

    // A write into a full FIFO is still taken when a read frees the slot.
    assign rd_en      = rd & ~empty;
    assign wr_en      = wr & (~full | rd_en);
    assign wr_ptr_inc = wr_ptr + ADDR_W'(1);
    assign rd_ptr_inc = rd_ptr + ADDR_W'(1);
    assign op         = fifo_op_e'({wr_en, rd_en});

    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        empty_nxt  = empty;
        full_nxt   = full;
        case (op)
            OP_WR: begin
                wr_ptr_nxt = wr_ptr_inc;
                empty_nxt  = 1'b0;
                full_nxt   = (wr_ptr_inc == rd_ptr);
            end
            OP_RD: begin
                rd_ptr_nxt = rd_ptr_inc;
                full_nxt   = 1'b0;
                empty_nxt  = (rd_ptr_inc == wr_ptr);
            end
            OP_WR_RD: begin
                wr_ptr_nxt = wr_ptr_inc;
                rd_ptr_nxt = rd_ptr_inc;
            end
            default: ;
        endcase
    end

    // loaded masks r_data to zero until the first byte lands after reset,
    // since the storage array itself is never cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            loaded <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            empty  <= empty_nxt;
            full   <= full_nxt;
            loaded <= loaded | wr_en;
        end
    end

`ifdef UART_RX_FIFO_OVF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf <= 1'b0;
        end else if (wr && full && !rd) begin
            ovf <= 1'b1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module      : uart_rx_fifo
// Description : First-word-fall-through byte FIFO between the UART receiver
//               and the operand collector. Optional sticky overflow output
//               enabled by defining UART_RX_FIFO_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DBIT   = UART_DBIT,
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr,
    input  logic [DBIT-1:0] w_data,
    input  logic            rd,
    output logic [DBIT-1:0] r_data,
    output logic            empty,
    output logic            full
`ifdef UART_RX_FIFO_OVF_EN
   ,output logic            ovf
`endif
);

    localparam int DEPTH = fifo_depth(ADDR_W);

    logic [DBIT-1:0]   mem [DEPTH];
    logic              wr_en;
    logic              loaded;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    uart_fifo_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_ctrl (
        .clk    (clk),
        .reset  (reset),
        .wr     (wr),
        .rd     (rd),
        .wr_en  (wr_en),
        .wr_ptr (wr_ptr),
        .rd_ptr (rd_ptr),
        .empty  (empty),
        .full   (full),
        .loaded (loaded)
`ifdef UART_RX_FIFO_OVF_EN
       ,.ovf    (ovf)
`endif
    );

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= w_data;
        end
    end

    assign r_data = loaded ? mem[rd_ptr] : '0;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Scoreboard bench for uart_rx_fifo; covers the ovf output when
//               UART_RX_FIFO_OVF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr;
    logic       rd;
    logic [7:0] w_data;
    logic [7:0] r_data;
    logic       empty;
    logic       full;
`ifdef UART_RX_FIFO_OVF_EN
    logic       ovf;
    logic       m_ovf;
`endif

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];

    uart_rx_fifo #(
        .DBIT   (8),
        .ADDR_W (4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .wr     (wr),
        .w_data (w_data),
        .rd     (rd),
        .r_data (r_data),
        .empty  (empty),
        .full   (full)
`ifdef UART_RX_FIFO_OVF_EN
       ,.ovf    (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle of stimulus, called 1 time unit after a rising edge.
    task automatic step(input logic w, input logic [7:0] d, input logic r);
        int  n;
        logic do_rd;
        logic do_wr;
        n     = exp_q.size();
        do_rd = r && (n > 0);
        do_wr = w && ((n < DEPTH) || do_rd);
        wr     = w;
        rd     = r;
        w_data = d;
        if (do_rd) check("r_data", r_data, exp_q.pop_front());
        if (do_wr) exp_q.push_back(d);
`ifdef UART_RX_FIFO_OVF_EN
        if (w && (n == DEPTH) && !r) m_ovf = 1'b1;
`endif
        @(posedge clk);
        #1;
        wr = 1'b0;
        rd = 1'b0;
        check("empty", empty, exp_q.size() == 0);
        check("full", full, exp_q.size() == DEPTH);
`ifdef UART_RX_FIFO_OVF_EN
        check("ovf", ovf, m_ovf);
`endif
    endtask

    initial begin
        reset  = 1'b0;
        wr     = 1'b0;
        rd     = 1'b0;
        w_data = 8'h00;
`ifdef UART_RX_FIFO_OVF_EN
        m_ovf  = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_r_data", r_data, 8'h00);
        reset = 1'b1;

        // Idle pops on an empty FIFO change nothing.
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        check("idle_r_data", r_data, 8'h00);

        // Single byte with fall-through visibility one edge after the write.
        step(1'b1, 8'hA5, 1'b0);
        check("single_head", r_data, 8'hA5);
        step(1'b0, 8'h00, 1'b1);

        // Fill to full, overflow attempt, then drain in order.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b1, 8'hFF, 1'b0);
        check("full_head", r_data, 8'h00);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1);

        // Pointer wrap-around.
        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1);

        // Simultaneous write and read on empty, then on full.
        step(1'b1, 8'h33, 1'b1);
        check("wr_rd_empty_head", r_data, 8'h33);
        for (int i = 1; i < DEPTH; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
        step(1'b1, 8'hC0, 1'b1);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1);

        // Asynchronous reset with five bytes stored.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h50 + i), 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("async_empty", empty, 1'b1);
        check("async_full", full, 1'b0);
        check("async_r_data", r_data, 8'h00);
`ifdef UART_RX_FIFO_OVF_EN
        check("async_ovf", ovf, 1'b0);
        m_ovf = 1'b0;
`endif
        exp_q.delete();
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 8'h77, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        check("drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
